pipe_stage_mux: RTL and testbench

Parametrised pipeline stage register with an N-way input select, a valid/ready handshake, a one-entry skid buffer and a synchronous flush. On each accepted transfer it registers one of NUM_IN candidate operands, replacing the single-bit clocked 2:1 select register in the datapath. It sits between CPU pipeline stages (for example, the operand-forwarding select in front of EX), so back-pressure and flushes are absorbed without losing or duplicating data. A saturating stall counter supports performance debug.

---
 rtl/pipe_stage_mux.sv | 64 ++++++
 tb/tb_pipe_stage_mux.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_mux.sv
// pipe_stage_mux: N-way select pipeline register with skid buffer, flush and saturating stall counter
module pipe_stage_mux #(
  parameter int WIDTH = 32,
  parameter int NUM_IN = 2,
  parameter int SEL_W = $clog2(NUM_IN),
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CNT_W-1:0]        stall_cnt
);
  logic [WIDTH-1:0] lane;
  logic [WIDTH-1:0] skid_data;
  logic             skid_valid;
  logic             accept;
  // out-of-range selects fall back to lane 0
  always_comb begin
    lane = in_data[WIDTH-1:0];
    for (int k = 1; k < NUM_IN; k++)
      if (sel == SEL_W'(k)) lane = in_data[k*WIDTH +: WIDTH];
  end
  assign in_ready = ~skid_valid;
  assign accept = in_valid & ~skid_valid;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      skid_valid <= 1'b0;
      out_data <= RESET_VAL;
      skid_data <= RESET_VAL;
      stall_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (flush) begin
        out_valid <= 1'b0;
        skid_valid <= 1'b0;
        out_data <= RESET_VAL;
      end else if (skid_valid) begin
        if (out_ready) begin
          out_data <= skid_data;
          skid_valid <= 1'b0;
        end
      end else if (accept) begin
        if (!out_valid || out_ready) begin
          out_data <= lane;
          out_valid <= 1'b1;
        end else begin
          skid_data <= lane;
          skid_valid <= 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pipe_stage_mux.sv
// tb_pipe_stage_mux: directed and randomised checks of the select/skid pipeline stage
module tb_pipe_stage_mux;
  localparam int W = 32, N = 3, SW = 2, CW = 4;
  logic clk = 0, rst = 1, in_valid = 0, flush = 0, out_ready = 0;
  logic [N*W-1:0] in_data = '0;
  logic [SW-1:0] sel = '0;
  logic in_ready, out_valid;
  logic [W-1:0] out_data;
  logic [CW-1:0] stall_cnt;
  int checks = 0, fails = 0;

  always #5 clk = ~clk;

  pipe_stage_mux #(.WIDTH(W), .NUM_IN(N), .RESET_VAL('0), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .stall_cnt(stall_cnt)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1; in_valid = 1; sel = 2;
    in_data = {32'h33333333, 32'h22222222, 32'h11111111};
    step; step;
    rst = 0; in_valid = 0;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin fails++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
    checks++; if (stall_cnt !== 4'd0) begin fails++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
    step;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_no_capture: got %0b expected 0", out_valid); end
  endtask

  task automatic test_select;
    logic [SW-1:0] sels [4] = '{2'd2, 2'd1, 2'd0, 2'd3};
    logic [W-1:0] exp [4] = '{32'h33333333, 32'h22222222, 32'h11111111, 32'h11111111};
    out_ready = 1; in_valid = 1;
    in_data = {32'h33333333, 32'h22222222, 32'h11111111};
    for (int i = 0; i < 4; i++) begin
      sel = sels[i];
      step;
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp[i]) begin
        fails++; $display("FAIL select_%0d: got valid=%0b data=%h expected valid=1 data=%h", i, out_valid, out_data, exp[i]);
      end
    end
    in_valid = 0;
    step;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL select_drain: got %0b expected 0", out_valid); end
  endtask

  task automatic test_back_pressure;
    int idx = 1;
    logic [W-1:0] got [$];
    sel = 0;
    for (int c = 0; c < 12; c++) begin
      out_ready = !(c >= 2 && c <= 4);
      in_valid = idx <= 6;
      in_data = {64'h0, W'(idx)};
      @(negedge clk);
      if (c == 3) begin
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready: got %0b expected 0", in_ready); end
        checks++; if (out_data !== 32'd2) begin fails++; $display("FAIL bp_held_data: got %0d expected 2", out_data); end
      end
      if (out_valid && out_ready) got.push_back(out_data);
      if (in_valid && in_ready) idx++;
      step;
    end
    in_valid = 0;
    checks++; if (got.size() != 6) begin fails++; $display("FAIL bp_count: got %0d expected 6", got.size()); end
    for (int i = 0; i < got.size() && i < 6; i++) begin
      checks++;
      if (got[i] !== W'(i + 1)) begin fails++; $display("FAIL bp_order_%0d: got %0d expected %0d", i, got[i], i + 1); end
    end
    checks++; if (stall_cnt !== 4'd3) begin fails++; $display("FAIL bp_stall_cnt: got %0d expected 3", stall_cnt); end
  endtask

  task automatic test_flush;
    out_ready = 0; in_valid = 1; sel = 0;
    in_data = {64'h0, 32'hAAAA0001};
    step;
    in_data = {64'h0, 32'hBBBB0002};
    step;
    checks++; if (in_ready !== 1'b0 || out_data !== 32'hAAAA0001) begin
      fails++; $display("FAIL flush_setup: got ready=%0b data=%h expected ready=0 data=aaaa0001", in_ready, out_data);
    end
    in_data = {64'h0, 32'hCCCC0003}; flush = 1;
    step;
    flush = 0; in_valid = 0;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_out_valid: got %0b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_in_ready: got %0b expected 1", in_ready); end
    checks++; if (out_data !== 32'h0) begin fails++; $display("FAIL flush_out_data: got %h expected 0", out_data); end
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      step;
      checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_no_output_%0d: got %0b expected 0", i, out_valid); end
    end
    flush = 1; in_valid = 1; in_data = {64'h0, 32'hDDDD0004};
    step;
    flush = 0; in_valid = 0;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_discard_accept: got %0b expected 0", out_valid); end
  endtask

  task automatic test_saturation;
    in_valid = 1; out_ready = 0; sel = 0; in_data = {64'h0, 32'hEEEE0005};
    step;
    in_valid = 0;
    for (int i = 0; i < 20; i++) step;
    checks++; if (stall_cnt !== 4'd15) begin fails++; $display("FAIL sat_stall_cnt: got %0d expected 15", stall_cnt); end
    checks++; if (out_valid !== 1'b1 || out_data !== 32'hEEEE0005) begin
      fails++; $display("FAIL sat_hold: got valid=%0b data=%h expected valid=1 data=eeee0005", out_valid, out_data);
    end
    flush = 1;
    step;
    flush = 0;
    checks++; if (stall_cnt !== 4'd15) begin fails++; $display("FAIL sat_after_flush: got %0d expected 15", stall_cnt); end
    rst = 1;
    step;
    rst = 0;
    checks++; if (stall_cnt !== 4'd0) begin fails++; $display("FAIL sat_after_rst: got %0d expected 0", stall_cnt); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL sat_rst_in_ready: got %0b expected 1", in_ready); end
  endtask

  task automatic test_random;
    logic [W-1:0] q [$];
    logic [W-1:0] lanes [N];
    logic [W-1:0] exp_lane;
    logic hold = 0, acc, drn;
    for (int c = 0; c < 10000; c++) begin
      if (!hold) begin
        in_valid = $urandom_range(0, 3) != 0;
        sel = SW'($urandom_range(0, 3));
        for (int k = 0; k < N; k++) lanes[k] = $urandom;
        in_data = {lanes[2], lanes[1], lanes[0]};
      end
      out_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 40) == 0;
      exp_lane = (sel == 2'd1) ? lanes[1] : (sel == 2'd2) ? lanes[2] : lanes[0];
      @(negedge clk);
      checks++; if (in_ready !== (q.size() < 2)) begin
        fails++; $display("FAIL rand_in_ready_%0d: got %0b expected %0b", c, in_ready, q.size() < 2);
      end
      checks++; if (out_valid !== (q.size() > 0)) begin
        fails++; $display("FAIL rand_out_valid_%0d: got %0b expected %0b", c, out_valid, q.size() > 0);
      end
      if (q.size() > 0) begin
        checks++; if (out_data !== q[0]) begin fails++; $display("FAIL rand_data_%0d: got %h expected %h", c, out_data, q[0]); end
      end
      acc = in_valid && q.size() < 2;
      drn = out_ready && q.size() > 0;
      hold = in_valid && !acc && !flush;
      if (flush) q.delete();
      else begin
        if (drn) void'(q.pop_front());
        if (acc) q.push_back(exp_lane);
      end
      step;
    end
    in_valid = 0; flush = 0;
  endtask

  initial begin
    test_reset;
    test_select;
    test_back_pressure;
    test_flush;
    test_saturation;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
